// File: rtl/bcd_conv_arbiter.sv
// Two-requester arbiter in front of a shared 8-bit binary to 3-digit BCD converter.
// Latency: grant in cycle C (combinational), result valid pulse in cycle C+9; one conversion per 10 cycles.
// Backpressure: requests are level-held until their gnt; no grant is issued while the engine is busy.
//
// Ports:
//   clk, rst              - single clock, asynchronous active-high reset
//   req0/bin0, req1/bin1  - level requests with 8-bit unsigned operands
//   gnt0, gnt1            - one-cycle accept pulses; operand sampled in the gnt cycle
//   busy                  - high from the cycle after a grant through the DONE cycle
//   valid                 - one-cycle pulse marking a new result
//   owner                 - requester index of the current or last conversion
//   bcd_hund/tens/ones    - result digits, held between valid pulses
//
// Build option: define BCD_ARB_ROUND_ROBIN_EN for round-robin contention handling
// (first contended winner is PRIORITY_INIT); otherwise requester 0 always wins contention.
module bcd_conv_arbiter #(
    parameter int unsigned PRIORITY_INIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] bin0,
    input  logic       req1,
    input  logic [7:0] bin1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       valid,
    output logic       owner,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // last_gnt holds the index of the requester granted most recently; it starts
    // as the opposite of PRIORITY_INIT so the first contended grant goes to PRIORITY_INIT.
    localparam logic LAST_INIT = (PRIORITY_INIT == 0) ? 1'b1 : 1'b0;

    state_t      state;
    logic [7:0]  shift_reg;
    logic [11:0] acc;
    logic [2:0]  shift_cnt;
    logic        last_gnt;

    logic        pick1;
    logic        can_grant;
    logic [11:0] acc_adj;
    logic [11:0] acc_next;

    // Winner selection assuming a grant is possible this cycle.
    always_comb begin
        pick1 = req1;
        if (req0 && req1) begin
`ifdef BCD_ARB_ROUND_ROBIN_EN
            pick1 = ~last_gnt;
`else
            pick1 = 1'b0;
`endif
        end
    end

`ifndef BCD_ARB_ROUND_ROBIN_EN
    // Fixed-priority build keeps the register but never consults it.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    // Gated by rst so grants stay low while reset is held, even with requests pending.
    assign can_grant = (state == IDLE) && !rst;
    assign gnt0      = can_grant && req0 && !pick1;
    assign gnt1      = can_grant && req1 && pick1;

    // Double-dabble correction: add 3 to every digit >= 5 before the shift.
    function automatic logic [11:0] add3_digits(input logic [11:0] a);
        logic [11:0] r;
        r = a;
        for (int d = 0; d < 3; d++) begin
            if (a[d*4 +: 4] >= 4'd5) begin
                r[d*4 +: 4] = a[d*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign acc_adj  = add3_digits(acc);
    assign acc_next = {acc_adj[10:0], shift_reg[7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= 8'd0;
            acc       <= 12'd0;
            shift_cnt <= 3'd0;
            last_gnt  <= LAST_INIT;
            busy      <= 1'b0;
            valid     <= 1'b0;
            owner     <= 1'b0;
            bcd_hund  <= 4'd0;
            bcd_tens  <= 4'd0;
            bcd_ones  <= 4'd0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        state     <= SHIFT;
                        shift_reg <= gnt1 ? bin1 : bin0;
                        acc       <= 12'd0;
                        shift_cnt <= 3'd0;
                        owner     <= gnt1;
                        last_gnt  <= gnt1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc       <= acc_next;
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    shift_cnt <= shift_cnt + 3'd1;
                    // Eighth shift: publish directly so the digits appear with valid in DONE.
                    if (shift_cnt == 3'd7) begin
                        state                          <= DONE;
                        valid                          <= 1'b1;
                        {bcd_hund, bcd_tens, bcd_ones} <= acc_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
module tb_bcd_conv_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] bin0, bin1;
    logic       gnt0, gnt1, busy, valid, owner;
    logic [3:0] bcd_hund, bcd_tens, bcd_ones;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(.PRIORITY_INIT(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .bin0     (bin0),
        .req1     (req1),
        .bin1     (bin1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .busy     (busy),
        .valid    (valid),
        .owner    (owner),
        .bcd_hund (bcd_hund),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones)
    );

    // Reference: decimal digits by plain division.
    function automatic logic [11:0] bcd_ref(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Drives one request and observes the DUT; returns raw observations only.
    task automatic run_conv(input bit who, input logic [7:0] val, input bit chg,
                            input logic [7:0] val2, output bit granted, output int lat,
                            output logic [11:0] res, output logic own, output logic busy_c1);
        granted = 1'b0;
        lat     = -1;
        res     = 12'hfff;
        own     = 1'bx;
        busy_c1 = 1'b0;
        @(negedge clk);
        if (who) begin req1 = 1'b1; bin1 = val; end
        else     begin req0 = 1'b1; bin0 = val; end
        for (int i = 0; i < 40 && !granted; i++) begin
            #1;
            if (who ? gnt1 : gnt0) granted = 1'b1;
            else @(negedge clk);
        end
        if (!granted) begin
            req0 = 1'b0;
            req1 = 1'b0;
            return;
        end
        @(negedge clk);
        busy_c1 = busy;
        // Operand is scrambled after the grant cycle; result must not depend on it.
        if (who) begin req1 = 1'b0; bin1 = chg ? val2 : 8'($urandom); end
        else     begin req0 = 1'b0; bin0 = chg ? val2 : 8'($urandom); end
        for (int k = 1; k <= 20; k++) begin
            if (valid) begin
                lat = k;
                res = {bcd_hund, bcd_tens, bcd_ones};
                own = owner;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; bin0 = 8'd55; bin1 = 8'd66;
        @(negedge clk);
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b expected 00", {gnt0, gnt1}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL reset_owner: got %b expected 0", owner); end
        checks++; if ({bcd_hund, bcd_tens, bcd_ones} !== 12'h000) begin failures++; $display("FAIL reset_digits: got %h expected 000", {bcd_hund, bcd_tens, bcd_ones}); end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fixed_vectors();
        bit           who_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int           val_t[4] = '{255, 0, 100, 9};
        bit           g;
        int           lat;
        logic [11:0]  res;
        logic         own, b1;
        for (int i = 0; i < 4; i++) begin
            run_conv(who_t[i], 8'(val_t[i]), 1'b0, 8'd0, g, lat, res, own, b1);
            checks++; if (g !== 1'b1) begin failures++; $display("FAIL fixed_grant[%0d]: got %b expected 1", i, g); end
            checks++; if (lat != 9) begin failures++; $display("FAIL fixed_latency[%0d]: got %0d expected 9", i, lat); end
            checks++; if (res !== bcd_ref(val_t[i])) begin failures++; $display("FAIL fixed_digits[%0d]: got %h expected %h", i, res, bcd_ref(val_t[i])); end
            checks++; if (own !== who_t[i]) begin failures++; $display("FAIL fixed_owner[%0d]: got %b expected %b", i, own, who_t[i]); end
            checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL fixed_busy[%0d]: got %b expected 1", i, b1); end
        end
    endtask

    task automatic test_hold();
        // Last result was 009 from requester 1; it must persist while idle.
        repeat (6) @(negedge clk);
        checks++; if ({bcd_hund, bcd_tens, bcd_ones} !== bcd_ref(9)) begin failures++; $display("FAIL hold_digits: got %h expected %h", {bcd_hund, bcd_tens, bcd_ones}, bcd_ref(9)); end
        checks++; if (owner !== 1'b1) begin failures++; $display("FAIL hold_owner: got %b expected 1", owner); end
        checks++; if ({valid, busy} !== 2'b00) begin failures++; $display("FAIL hold_valid_busy: got %b expected 00", {valid, busy}); end
    endtask

    task automatic test_operand_change();
        bit          g;
        int          lat;
        logic [11:0] res;
        logic        own, b1;
        run_conv(1'b0, 8'd123, 1'b1, 8'd45, g, lat, res, own, b1);
        checks++; if (res !== bcd_ref(123)) begin failures++; $display("FAIL operand_change: got %h expected %h", res, bcd_ref(123)); end
        checks++; if (lat != 9) begin failures++; $display("FAIL operand_change_latency: got %0d expected 9", lat); end
    endtask

    task automatic test_random();
        bit          g, who;
        int          lat, v;
        logic [11:0] res;
        logic        own, b1;
        for (int i = 0; i < 20; i++) begin
            who = 1'($urandom);
            v   = int'($urandom_range(255, 0));
            run_conv(who, 8'(v), 1'b0, 8'd0, g, lat, res, own, b1);
            checks++; if (lat != 9 || res !== bcd_ref(v) || own !== who) begin
                failures++;
                $display("FAIL random[%0d] bin=%0d: got lat=%0d digits=%h owner=%b expected lat=9 digits=%h owner=%b",
                         i, v, lat, res, own, bcd_ref(v), who);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gcyc[8];
        bit gwho[8];
        int ngr  = 0;
        int both = 0;
        bit exp_who;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; bin0 = 8'd77; bin1 = 8'd88;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (gnt0 && gnt1) both++;
            if ((gnt0 || gnt1) && ngr < 8) begin
                gcyc[ngr] = c;
                gwho[ngr] = gnt1;
                ngr++;
            end
            @(negedge clk);
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (both != 0) begin failures++; $display("FAIL b2b_both_granted: got %0d cycles expected 0", both); end
        checks++; if (ngr != 4) begin failures++; $display("FAIL b2b_grant_count: got %0d expected 4", ngr); end
        for (int i = 0; i < 4 && i < ngr; i++) begin
`ifdef BCD_ARB_ROUND_ROBIN_EN
            exp_who = 1'(i % 2);
`else
            exp_who = 1'b0;
`endif
            checks++; if (gcyc[i] != 10 * i || gwho[i] !== exp_who) begin
                failures++;
                $display("FAIL b2b_grant[%0d]: got cycle=%0d who=%b expected cycle=%0d who=%b",
                         i, gcyc[i], gwho[i], 10 * i, exp_who);
            end
        end
    endtask

    task automatic test_mid_reset();
        int lat = -1;
        @(negedge clk);
        req0 = 1'b1; bin0 = 8'd200;
        #1;
        checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL midrst_grant: got %b expected 1", gnt0); end
        @(negedge clk);          // cycle C+1
        req0 = 1'b0;
        repeat (3) @(negedge clk); // cycle C+4, fourth shift cycle
        rst = 1'b1;
        #1;
        checks++; if ({busy, valid, owner} !== 3'b000) begin failures++; $display("FAIL midrst_flags: got busy,valid,owner=%b expected 000", {busy, valid, owner}); end
        checks++; if ({bcd_hund, bcd_tens, bcd_ones} !== 12'h000) begin failures++; $display("FAIL midrst_digits: got %h expected 000", {bcd_hund, bcd_tens, bcd_ones}); end
        @(negedge clk);
        rst = 1'b0; req1 = 1'b1; bin1 = 8'd37;
        #1;
        checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL midrst_regrant: got %b expected 1", gnt1); end
        @(negedge clk);
        req1 = 1'b0; bin1 = 8'd0;
        for (int k = 1; k <= 20; k++) begin
            if (valid) begin lat = k; break; end
            @(negedge clk);
        end
        checks++; if (lat != 9) begin failures++; $display("FAIL midrst_first_valid: got cycle %0d expected 9", lat); end
        checks++; if ({bcd_hund, bcd_tens, bcd_ones} !== bcd_ref(37) || owner !== 1'b1) begin
            failures++;
            $display("FAIL midrst_result: got %h owner=%b expected %h owner=1", {bcd_hund, bcd_tens, bcd_ones}, owner, bcd_ref(37));
        end
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = 8'd0; bin1 = 8'd0;
        test_reset();
        test_fixed_vectors();
        test_hold();
        test_operand_change();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 The parameter list SHALL be: PRIORITY_INIT, default 0, index of the requester that wins the first contended grant after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0  input  1  requester 0 conversion request, level, held until gnt0.
REQ-005 bin0  input  8  requester 0 unsigned binary operand, valid while req0=1.
REQ-006 req1  input  1  requester 1 conversion request, level, held until gnt1.
REQ-007 bin1  input  8  requester 1 unsigned binary operand, valid while req1=1.
REQ-008 gnt0, gnt1  output  1 each  one-cycle accept pulses; the operand SHALL be sampled in the gnt cycle.
REQ-009 busy  output  1  high from the cycle after a grant through the DONE cycle.
REQ-010 valid  output  1  one-cycle pulse marking a new result.
REQ-011 owner  output  1  index of the requester owning the current or last result.
REQ-012 bcd_hund, bcd_tens, bcd_ones  output  4 each  hundreds, tens and ones digits, each 0..9.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE: IDLE->SHIFT on grant, SHIFT->DONE after exactly 8 shift cycles, DONE->IDLE unconditionally.
REQ-014 gnt0/gnt1 SHALL be combinational, asserted only in IDLE, at most one high per cycle, and never asserted when the matching req is low.
REQ-015 Arbitration with a single requester SHALL grant it; with both requesting it SHALL grant the requester not granted last (round-robin, see REQ-026).
REQ-016 On a grant the engine SHALL load the selected operand into an 8-bit shift register, clear the 12-bit BCD accumulator and latch owner.
REQ-017 Each SHIFT cycle SHALL first add 3 to every accumulator digit >=5, then shift {accumulator, shift register} left by one bit; no correction SHALL follow the 8th shift.
REQ-018 In DONE, valid SHALL pulse and the digit outputs SHALL show the accumulator, so grant in cycle C yields valid in cycle C+9.
REQ-019 The digit outputs and owner SHALL hold their values between valid pulses.
REQ-020 Requests raised while busy SHALL wait; a request dropped before its grant SHALL be discarded silently.
REQ-021 Peak throughput SHALL be one conversion per 10 cycles; no grant SHALL occur in SHIFT or DONE.
REQ-022 Operand changes after the grant cycle SHALL NOT affect the conversion in progress.

Reset
REQ-023 Asserting rst in any state, including mid-SHIFT, SHALL immediately force IDLE and discard the conversion in progress without a valid pulse.
REQ-024 Reset values SHALL be: gnt0=gnt1=0, busy=0, valid=0, owner=0, all digits 0, and the last-granted register = ~PRIORITY_INIT.
REQ-025 The first rising clk edge after rst deasserts SHALL be able to produce a grant.

Configuration
REQ-026 With macro BCD_ARB_ROUND_ROBIN_EN defined, contended arbitration SHALL be round-robin per REQ-015; without it, req0 SHALL always win contention, and PRIORITY_INIT and the last-granted register SHALL have no effect.

Verification
REQ-027 req0=1, bin0=255, idle engine -> gnt0 in cycle C, valid in C+9 with digits 2,5,5 and owner=0.
REQ-028 bin1=0, then bin1=100, then bin1=9 -> digits 0,0,0, then 1,0,0, then 0,0,9.
REQ-029 req0 and req1 held high with macro defined, PRIORITY_INIT=0 -> grants alternate 0,1,0,1 at 10-cycle spacing; without the macro -> all grants go to 0.
REQ-030 rst pulsed in the 4th SHIFT cycle of a bin0=200 conversion -> no valid pulse, all outputs 0, busy=0, and a new request is granted on the first edge after release.
REQ-031 bin0 changed from 123 to 45 one cycle after gnt0 -> result digits 1,2,3.
